// File: rtl/axi_rd_arb_pkg.sv
// Shared constants, state type and AXI size helper for the read-channel arbiter.
package axi_rd_arb_pkg;

   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'd3;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // AXI size code is log2 of the bytes per beat.
   function automatic logic [2:0] axi_size(input int data_width);
      int         bytes;
      logic [2:0] sz;
      bytes = data_width / 8;
      sz    = '0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == bytes) sz = 3'(i);
      end
      return sz;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!any && req[IDX_W'(j)]) begin
            any                = 1'b1;
            grant[IDX_W'(j)]   = 1'b1;
            grant_idx          = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read arbiter: registered AR stage, ARID = requester index, RID-steered R path.
// Define AXI_RD_ARB_OSTD_LIMIT_EN to cap outstanding bursts per requester at MAX_OSTD.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int IN_NUM     = 5,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 64,
   parameter int MAX_OSTD   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [IN_NUM*ADDR_WIDTH-1:0] s_araddr,
   input  logic [IN_NUM*8-1:0]          s_arlen,
   input  logic [IN_NUM-1:0]            s_arvalid,
   output logic [IN_NUM-1:0]            s_arready,
   output logic [IN_NUM*DATA_WIDTH-1:0] s_rdata,
   output logic [IN_NUM-1:0]            s_rvalid,
   output logic [IN_NUM-1:0]            s_rlast,
   input  logic [IN_NUM-1:0]            s_rready,
   output logic [ADDR_WIDTH-1:0]        araddr,
   output logic [7:0]                   arlen,
   output logic [ID_WIDTH-1:0]          arid,
   output logic                         arvalid,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic [3:0]                   arcache,
   output logic [2:0]                   arprot,
   output logic                         arlock,
   output logic [3:0]                   arqos,
   output logic [3:0]                   arregion,
   input  logic                         arready,
   input  logic [DATA_WIDTH-1:0]        rdata,
   input  logic [ID_WIDTH-1:0]          rid,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready,
   output logic                         rid_err
);

   localparam int IDX_W = $clog2(IN_NUM);
   localparam logic [0:0] S_ARB  = ARB;
   localparam logic [0:0] S_HOLD = HOLD;

   logic [0:0]            state;
   logic [IDX_W-1:0]      ptr;
   logic [IDX_W-1:0]      grant_q;
   logic [IDX_W-1:0]      grant_idx;
   logic [IN_NUM-1:0]     grant_oh;
   logic [IN_NUM-1:0]     eligible;
   logic [IN_NUM-1:0]     full;
   logic                  any;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [7:0]            req_len;
   logic                  rid_ok;
   logic                  unused_rresp;

   assign unused_rresp = ^rresp;

   assign eligible = s_arvalid & ~full;

   rr_arbiter #(.N(IN_NUM)) u_rr (
      .req       (eligible),
      .ptr       (ptr),
      .grant     (grant_oh),
      .grant_idx (grant_idx),
      .any       (any)
   );

   always_comb begin
      req_addr = '0;
      req_len  = '0;
      for (int k = 0; k < IN_NUM; k++) begin
         if (grant_oh[k]) begin
            req_addr = req_addr | s_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            req_len  = req_len  | s_arlen[k*8 +: 8];
         end
      end
   end

   // The AR stage is captured once per grant and held untouched until the master accepts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_ARB;
         ptr     <= '0;
         grant_q <= '0;
         araddr  <= '0;
         arlen   <= '0;
         arid    <= '0;
      end else begin
         case (state)
            S_ARB: begin
               if (any) begin
                  araddr  <= req_addr;
                  arlen   <= req_len;
                  arid    <= ID_WIDTH'(grant_idx);
                  grant_q <= grant_idx;
                  state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (arready) begin
                  ptr   <= (grant_q == IDX_W'(IN_NUM - 1)) ? '0 : grant_q + 1'b1;
                  state <= S_ARB;
               end
            end
         endcase
      end
   end

   assign arvalid = (state == S_HOLD);

   always_comb begin
      s_arready = '0;
      if (state == S_HOLD && arready) s_arready[grant_q] = 1'b1;
   end

   assign arsize   = axi_size(DATA_WIDTH);
   assign arburst  = AXI_BURST_INCR;
   assign arcache  = AXI_CACHE_DEFAULT;
   assign arprot   = '0;
   assign arlock   = 1'b0;
   assign arqos    = '0;
   assign arregion = '0;

   // Beats carrying an out-of-range RID are accepted and discarded so the master never stalls.
   always_comb begin
      rid_ok   = 1'b0;
      rready   = 1'b1;
      s_rvalid = '0;
      s_rlast  = '0;
      for (int k = 0; k < IN_NUM; k++) begin
         if (rid == ID_WIDTH'(k)) begin
            rid_ok      = 1'b1;
            rready      = s_rready[k];
            s_rvalid[k] = rvalid;
            s_rlast[k]  = rlast;
         end
      end
   end

   assign rid_err = rvalid & ~rid_ok;
   assign s_rdata = {IN_NUM{rdata}};

`ifdef AXI_RD_ARB_OSTD_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_OSTD + 1);

   logic [CNT_W-1:0]  ostd_cnt [IN_NUM];
   logic [IN_NUM-1:0] r_done;

   always_comb begin
      for (int k = 0; k < IN_NUM; k++) begin
         r_done[k] = s_rvalid[k] & s_rready[k] & s_rlast[k];
         full[k]   = (ostd_cnt[k] == CNT_W'(MAX_OSTD));
      end
   end

   // An AR handshake and a closing rlast in the same cycle cancel; decrement saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < IN_NUM; k++) ostd_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < IN_NUM; k++) begin
            case ({s_arready[k], r_done[k]})
               2'b10:   ostd_cnt[k] <= ostd_cnt[k] + 1'b1;
               2'b01:   if (ostd_cnt[k] != '0) ostd_cnt[k] <= ostd_cnt[k] - 1'b1;
               default: ;
            endcase
         end
      end
   end
`else
   localparam int unused_max_ostd = MAX_OSTD;

   assign full = '0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR grants and R routing results are queued as stimulus is driven.
module tb_axi_rd_arbiter;

   localparam int IN_NUM     = 5;
   localparam int ID_WIDTH   = 4;
   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 64;
   localparam int MAX_OSTD   = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [IN_NUM*ADDR_WIDTH-1:0] s_araddr;
   logic [IN_NUM*8-1:0]          s_arlen;
   logic [IN_NUM-1:0]            s_arvalid;
   logic [IN_NUM-1:0]            s_arready;
   logic [IN_NUM*DATA_WIDTH-1:0] s_rdata;
   logic [IN_NUM-1:0]            s_rvalid;
   logic [IN_NUM-1:0]            s_rlast;
   logic [IN_NUM-1:0]            s_rready;
   logic [ADDR_WIDTH-1:0]        araddr;
   logic [7:0]                   arlen;
   logic [ID_WIDTH-1:0]          arid;
   logic                         arvalid;
   logic [2:0]                   arsize;
   logic [1:0]                   arburst;
   logic [3:0]                   arcache;
   logic [2:0]                   arprot;
   logic                         arlock;
   logic [3:0]                   arqos;
   logic [3:0]                   arregion;
   logic                         arready;
   logic [DATA_WIDTH-1:0]        rdata;
   logic [ID_WIDTH-1:0]          rid;
   logic [1:0]                   rresp;
   logic                         rlast;
   logic                         rvalid;
   logic                         rready;
   logic                         rid_err;

   axi_rd_arbiter #(
      .IN_NUM(IN_NUM), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH), .MAX_OSTD(MAX_OSTD)
   ) dut (
      .clk(clk), .rst(rst),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
      .araddr(araddr), .arlen(arlen), .arid(arid), .arvalid(arvalid),
      .arsize(arsize), .arburst(arburst), .arcache(arcache), .arprot(arprot),
      .arlock(arlock), .arqos(arqos), .arregion(arregion), .arready(arready),
      .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready), .rid_err(rid_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [ID_WIDTH-1:0]   id;
   } ar_exp_t;

   typedef struct packed {
      logic [IN_NUM-1:0]     sv;
      logic [IN_NUM-1:0]     sl;
      logic                  rr;
      logic                  err;
      logic [DATA_WIDTH-1:0] data;
   } r_exp_t;

   ar_exp_t           exp_ar[$];
   r_exp_t            exp_r[$];
   int                hs_cyc[$];
   int                checks  = 0;
   int                fails   = 0;
   int                cyc     = 0;
   int                ar_seen = 0;
   int                base;
   logic [IN_NUM-1:0] keep = '0;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int k, input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len);
      s_araddr[k*ADDR_WIDTH +: ADDR_WIDTH] = addr;
      s_arlen[k*8 +: 8]                    = len;
      s_arvalid[k]                         = 1'b1;
   endtask

   task automatic pushAr(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len, input int id);
      ar_exp_t e;
      e.addr = addr;
      e.len  = len;
      e.id   = ID_WIDTH'(id);
      exp_ar.push_back(e);
   endtask

   task automatic sendBeat(input int id, input logic [DATA_WIDTH-1:0] data, input logic last,
                           input logic [IN_NUM-1:0] rr_mask, input logic exp_rr);
      r_exp_t e;
      e.sv   = (id < IN_NUM) ? (IN_NUM'(1) << id) : '0;
      e.sl   = last ? e.sv : '0;
      e.rr   = exp_rr;
      e.err  = (id >= IN_NUM);
      e.data = data;
      exp_r.push_back(e);
      s_rready = rr_mask;
      rid      = ID_WIDTH'(id);
      rdata    = data;
      rlast    = last;
      rresp    = 2'b10;
      rvalid   = 1'b1;
      @(posedge clk);
      #2;
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   task automatic waitAr(input int target);
      int n;
      n = 0;
      #1;
      while (ar_seen < target && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (ar_seen < target) checkOutput("ar_timeout", 64'(ar_seen), 64'(target));
      @(posedge clk);
      #2;
   endtask

   // Monitor: pops expected AR and R results on the falling edge.
   always @(negedge clk) begin
      ar_exp_t ea;
      r_exp_t  er;
      cyc++;
      if (!rst && arvalid && arready) begin
         checkOutput("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
         if (exp_ar.size() > 0) begin
            ea = exp_ar.pop_front();
            checkOutput("araddr", 64'(araddr), 64'(ea.addr));
            checkOutput("arlen", 64'(arlen), 64'(ea.len));
            checkOutput("arid", 64'(arid), 64'(ea.id));
            checkOutput("s_arready_hs", 64'(s_arready), 64'd1 << ea.id);
         end
         ar_seen++;
         hs_cyc.push_back(cyc);
      end else begin
         checkOutput("s_arready_idle", 64'(s_arready), 64'd0);
      end
      if (rvalid) begin
         checkOutput("r_expected", 64'(exp_r.size() > 0), 64'd1);
         if (exp_r.size() > 0) begin
            er = exp_r.pop_front();
            checkOutput("s_rvalid", 64'(s_rvalid), 64'(er.sv));
            checkOutput("s_rlast", 64'(s_rlast), 64'(er.sl));
            checkOutput("rready", 64'(rready), 64'(er.rr));
            checkOutput("rid_err", 64'(rid_err), 64'(er.err));
            for (int k = 0; k < IN_NUM; k++)
               checkOutput("s_rdata", 64'(s_rdata[k*DATA_WIDTH +: DATA_WIDTH]), 64'(er.data));
         end
      end
   end

   // Requesters release their request after acceptance unless held continuously.
   initial begin : ar_dropper
      logic [IN_NUM-1:0] acc;
      forever begin
         @(negedge clk);
         if (|s_arready) begin
            acc = s_arready & ~keep;
            @(posedge clk);
            #1;
            s_arvalid = s_arvalid & ~acc;
         end
      end
   end

   initial begin
      rst       = 1'b1;
      s_arvalid = '0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_rready  = '1;
      arready   = 1'b0;
      rdata     = '0;
      rid       = '0;
      rresp     = '0;
      rlast     = 1'b0;
      rvalid    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
      checkOutput("rst_araddr", 64'(araddr), 64'd0);
      checkOutput("rst_arlen", 64'(arlen), 64'd0);
      checkOutput("rst_arid", 64'(arid), 64'd0);
      checkOutput("rst_rid_err", 64'(rid_err), 64'd0);
      checkOutput("arsize", 64'(arsize), 64'd3);
      checkOutput("arburst", 64'(arburst), 64'd1);
      checkOutput("arcache", 64'(arcache), 64'd3);
      checkOutput("arprot", 64'(arprot), 64'd0);
      checkOutput("arlock", 64'(arlock), 64'd0);
      checkOutput("arqos", 64'(arqos), 64'd0);
      checkOutput("arregion", 64'(arregion), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      $display("[TB] round-robin fairness");
      arready = 1'b1;
      keep    = '1;
      hs_cyc.delete();
      for (int k = 0; k < IN_NUM; k++) applyStimulus(k, 64'(256 * (k + 1)), 8'(k));
      for (int i = 0; i < 6; i++) pushAr(64'(256 * ((i % 5) + 1)), 8'(i % 5), i % 5);
      waitAr(6);
      s_arvalid = '0;
      keep      = '0;
      for (int i = 0; i < 5; i++) checkOutput("rr_gap", 64'(hs_cyc[i+1] - hs_cyc[i]), 64'd2);
      sendBeat(0, 64'hA0, 1'b1, '1, 1'b1);
      sendBeat(0, 64'hA1, 1'b1, '1, 1'b1);
      for (int k = 1; k < IN_NUM; k++) sendBeat(k, 64'(16 * k), 1'b1, '1, 1'b1);

      $display("[TB] single request");
      applyStimulus(2, 64'h1000, 8'd3);
      pushAr(64'h1000, 8'd3, 2);
      @(negedge clk);
      checkOutput("lat_before", 64'(arvalid), 64'd0);
      @(negedge clk);
      checkOutput("lat_arvalid", 64'(arvalid), 64'd1);
      checkOutput("lat_arid", 64'(arid), 64'd2);
      waitAr(7);
      sendBeat(2, 64'hEE, 1'b0, 5'b11011, 1'b0);
      for (int b = 0; b < 4; b++) sendBeat(2, 64'(64'hD000 + b), (b == 3), '1, 1'b1);

      $display("[TB] backpressure");
      arready = 1'b0;
      applyStimulus(4, 64'h4444, 8'd7);
      pushAr(64'h4444, 8'd7, 4);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_arvalid", 64'(arvalid), 64'd1);
         checkOutput("bp_araddr", 64'(araddr), 64'h4444);
         checkOutput("bp_arid", 64'(arid), 64'd4);
      end
      @(posedge clk);
      #2;
      arready = 1'b1;
      base    = ar_seen;
      @(negedge clk);
      #1;
      checkOutput("bp_hs_cycle", 64'(ar_seen), 64'(base + 1));
      waitAr(base + 1);
      sendBeat(4, 64'h44, 1'b1, '1, 1'b1);

      $display("[TB] bad rid");
      sendBeat(7, 64'h77, 1'b1, '0, 1'b1);
      sendBeat(5, 64'h55, 1'b0, '0, 1'b1);
      sendBeat(1, 64'h15, 1'b0, '0, 1'b0);

      $display("[TB] outstanding limit");
      base = ar_seen;
      applyStimulus(0, 64'hA000, 8'd0);
      pushAr(64'hA000, 8'd0, 0);
      waitAr(base + 1);
      applyStimulus(0, 64'hB000, 8'd0);
      pushAr(64'hB000, 8'd0, 0);
      waitAr(base + 2);
`ifdef AXI_RD_ARB_OSTD_LIMIT_EN
      applyStimulus(0, 64'hC000, 8'd0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("ostd_block", 64'(arvalid), 64'd0);
      end
      @(posedge clk);
      #2;
      applyStimulus(1, 64'hD000, 8'd1);
      pushAr(64'hD000, 8'd1, 1);
      waitAr(base + 3);
      pushAr(64'hC000, 8'd0, 0);
      sendBeat(0, 64'hC0, 1'b1, '1, 1'b1);
      waitAr(base + 4);
`else
      applyStimulus(0, 64'hC000, 8'd0);
      pushAr(64'hC000, 8'd0, 0);
      waitAr(base + 3);
      applyStimulus(1, 64'hD000, 8'd1);
      pushAr(64'hD000, 8'd1, 1);
      waitAr(base + 4);
`endif

      $display("[TB] reset during hold");
      arready = 1'b0;
      applyStimulus(3, 64'h3000, 8'd1);
      repeat (2) @(negedge clk);
      checkOutput("hold_arvalid", 64'(arvalid), 64'd1);
      checkOutput("hold_arid", 64'(arid), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_hold_arvalid", 64'(arvalid), 64'd0);
      checkOutput("rst_hold_araddr", 64'(araddr), 64'd0);
      @(posedge clk);
      #2;
      sendBeat(1, 64'h11, 1'b1, '1, 1'b1);
      applyStimulus(0, 64'h0F00, 8'd2);
      @(posedge clk);
      #2;
      rst     = 1'b0;
      arready = 1'b1;
      base    = ar_seen;
      pushAr(64'h0F00, 8'd2, 0);
      pushAr(64'h3000, 8'd1, 3);
      waitAr(base + 2);

      repeat (3) @(negedge clk);
      checkOutput("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
      checkOutput("r_queue_drained", 64'(exp_r.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin read-channel arbiter that shares one AXI4 master read port between IN_NUM requesters in the simulation BFM. It selects one pending AR request per arbitration, drives a registered AR stage, stamps ARID with the requester index, and steers R beats back to the originating requester by RID. An optional per-requester outstanding-burst limit throttles requesters that run too far ahead of the downstream memory model.

## Interface
- IN_NUM, 5, number of requesters (2..16)
- ID_WIDTH, 4, ARID/RID width; must satisfy 2^ID_WIDTH >= IN_NUM
- DATA_WIDTH, 512, read data width
- ADDR_WIDTH, 64, address width
- MAX_OSTD, 8, outstanding AR bursts allowed per requester (used only with the limit feature)

Ports:
- clk  in  1  single clock; every register is clocked by it
- rst  in  1  asynchronous, active-high reset
- s_araddr  in  IN_NUM*ADDR_WIDTH  per-requester read address
- s_arlen  in  IN_NUM*8  per-requester burst length minus 1
- s_arvalid  in  IN_NUM  per-requester request valid
- s_arready  out  IN_NUM  per-requester request accepted
- s_rdata  out  IN_NUM*DATA_WIDTH  read data, broadcast to all requesters
- s_rvalid  out  IN_NUM  per-requester read beat valid
- s_rlast  out  IN_NUM  per-requester last beat
- s_rready  in  IN_NUM  per-requester beat accept
- araddr, arlen, arid, arvalid  out  ADDR_WIDTH/8/ID_WIDTH/1  master AR channel
- arsize, arburst, arcache, arprot, arlock, arqos, arregion  out  3/2/4/3/1/4/4  master AR constants
- arready  in  1  master AR ready
- rdata, rid, rresp, rlast, rvalid  in  DATA_WIDTH/ID_WIDTH/2/1/1  master R channel
- rready  out  1  master R ready
- rid_err  out  1  one-cycle pulse on an R handshake whose RID >= IN_NUM

## Operation
- AR state machine, two states:
  - **ARB**
    - arvalid=0.
    - Eligible set = s_arvalid masked by the outstanding limit.
    - If the set is non-empty, the rr_arbiter picks the first eligible index at or after ptr.
    - Capture araddr, arlen, and arid=grant into the registered AR stage; go to HOLD.
  - **HOLD**
    - arvalid=1 and the AR stage stays stable.
    - On arready: s_arready[grant]=1 for that cycle, ptr <= (grant+1) mod IN_NUM, return to ARB.
- Requesters hold s_arvalid, s_araddr and s_arlen until s_arready, per AXI rules. A requester dropping s_arvalid while in HOLD is a protocol violation; the bench must not do it.
- Constant AR fields:
  - arsize = log2(DATA_WIDTH/8)
  - arburst = 2'b01 (INCR)
  - arcache = 4'd3
  - arprot, arlock, arqos, arregion = 0
- R routing is combinational:
  - s_rvalid[k] = rvalid & (rid==k)
  - s_rlast[k] = rlast & (rid==k)
  - s_rdata = rdata to all requesters
  - rready = s_rready[rid]
- RID >= IN_NUM: rready=1 (beat is dropped) and rid_err pulses for each such handshake.
- rresp is not forwarded.

## Timing
- Reset values:
  - arvalid, araddr, arlen, arid, s_arready, rid_err = 0
  - ptr = 0, state = ARB, all outstanding counters = 0
- Latency:
  - s_arvalid rising in cycle N gives arvalid=1 in cycle N+1.
  - With arready held high, that request handshakes in N+1.
  - Minimum 2 cycles per grant, so back-to-back requests from different requesters are issued at one every 2 cycles.
- s_arready is never asserted outside the downstream handshake cycle.
- R path has zero latency; no R buffering.
- Reset asserted mid-HOLD clears arvalid immediately (asynchronous). Any in-flight R beats arriving after reset are routed normally. Counters stay at 0 and never underflow.
- ptr wraps from IN_NUM-1 to 0.

## Configuration
- **AXI_RD_ARB_OSTD_LIMIT_EN** defined:
  - Each requester has a counter of width $clog2(MAX_OSTD+1).
  - +1 on its AR handshake, −1 on an R handshake with rlast for its RID. Simultaneous increment and decrement leaves it unchanged.
  - Requester k is ineligible in ARB while counter[k] == MAX_OSTD.
  - Decrement at 0 saturates at 0.
- Not defined: no counters; eligible set = s_arvalid.

## Structure
- Package axi_rd_arb_pkg holds:
  - AXI_BURST_INCR = 2'b01
  - AXI_CACHE_DEFAULT = 4'd3
  - the state enum {ARB, HOLD}
  - the function computing arsize from DATA_WIDTH
- Sub-module rr_arbiter, parameterised by N:
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational.

## Test plan
- **Single request**
  - Stimulus: requester 2 issues araddr=0x1000, arlen=3; arready=1.
  - Expect: arvalid in the next cycle with arid=2; s_arready[2] pulses once; 4 R beats with rid=2 appear only on s_rvalid[2], with s_rlast[2] on beat 4.
- **Round-robin fairness**
  - Stimulus: all 5 requesters continuously valid.
  - Expect: grant order 0,1,2,3,4,0 and each grant one arvalid per 2 cycles.
- **Backpressure**
  - Stimulus: arready=0 for 10 cycles during HOLD.
  - Expect: araddr/arid stable, no s_arready; handshake on the cycle arready rises.
- **Outstanding limit (macro on, MAX_OSTD=2)**
  - Stimulus: requester 0 issues 3 bursts with R withheld.
  - Expect: third request is not granted and requester 1 is served instead; after one rlast to rid=0, the third request is granted.
- **Bad RID**
  - Stimulus: rvalid with rid=7 (IN_NUM=5).
  - Expect: rready=1, all s_rvalid=0, rid_err=1 for that cycle.
- **Reset mid-HOLD**
  - Stimulus: assert rst during HOLD.
  - Expect: arvalid=0 in the same cycle; after release, the first grant starts from ptr=0.
